// File: rtl/shift_loader_if.sv
// shift_loader_if: start/data handshake and serial outputs of the shift loader.
interface shift_loader_if;
    logic       start;
    logic [7:0] din;
    logic       DS;
    logic       SH_CP;
    logic       ST_CP;
    logic       busy;
    logic       done;
    modport master (output start, din, input DS, SH_CP, ST_CP, busy, done);
    modport slave  (input start, din, output DS, SH_CP, ST_CP, busy, done);
endinterface

// File: rtl/shift_loader.sv
// shift_loader: serializes one byte into a shift/storage register pair (SH_CP, ST_CP, DS).
module shift_loader #(
    parameter int   DIV       = 4,
    parameter logic MSB_FIRST = 1'b1,
    parameter logic INVERT    = 1'b1
) (
    input  logic          clk,
    input  logic          MR,
    shift_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LATCH, DONE} state_t;
    state_t     state_q;
    logic [7:0] tmr_q;
    logic [7:0] buf_q;
    logic [7:0] buf_d;
    logic [3:0] cnt_q;
    logic       ds_q;
    logic       sh_q;
    logic       st_q;
    logic       busy_q;
    logic       done_q;
    logic       last;
    assign last  = tmr_q == 8'(DIV - 1);
    assign buf_d = MSB_FIRST ? {buf_q[6:0], 1'b0} : {1'b0, buf_q[7:1]};
    always_ff @(posedge clk or negedge MR) begin
        if (!MR) begin
            state_q <= IDLE;
            tmr_q   <= 8'd0;
            cnt_q   <= 4'd0;
            buf_q   <= 8'h00;
            ds_q    <= INVERT;
            sh_q    <= 1'b0;
            st_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            tmr_q  <= (state_q == IDLE || state_q == DONE || last) ? 8'd0 : tmr_q + 8'd1;
            case (state_q)
                IDLE: if (bus.start) begin
                    buf_q   <= bus.din;
                    cnt_q   <= 4'd0;
                    ds_q    <= (MSB_FIRST ? bus.din[7] : bus.din[0]) ^ INVERT;
                    busy_q  <= 1'b1;
                    state_q <= SETUP;
                end
                SETUP: if (last) begin
                    sh_q    <= 1'b1;
                    state_q <= HIGH;
                end
                HIGH: if (last) begin
                    buf_q <= buf_d;
                    cnt_q <= cnt_q + 4'd1;
                    sh_q  <= 1'b0;
                    // DS keeps the last bit through LATCH
                    if (cnt_q == 4'd7) begin
                        st_q    <= 1'b1;
                        state_q <= LATCH;
                    end else begin
                        ds_q    <= (MSB_FIRST ? buf_d[7] : buf_d[0]) ^ INVERT;
                        state_q <= SETUP;
                    end
                end
                LATCH: if (last) begin
                    st_q    <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.DS    = ds_q;
    assign bus.SH_CP = sh_q;
    assign bus.ST_CP = st_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule
